// File: rtl/array_pkg.sv
// Shared definitions for the systolic array result path.
// Provides default lane count and word width, lane/row types and the
// collector state encoding used by result_collector.
package array_pkg;

    localparam int DEF_STRIDE = 4;
    localparam int DEF_WIDTH  = 32;

    typedef logic [DEF_WIDTH-1:0] lane_word_t;
    typedef lane_word_t [DEF_STRIDE-1:0] row_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } col_state_t;

endpackage

// File: rtl/lane_wr_ptr.sv
// Per-lane saturating write pointer for the result collector.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   clear       - restart: pointer and overflow flag return to zero
//   vld         - lane write strobe
//   waddr       - row the next accepted word is written to
//   we          - this cycle's strobe is accepted into memory
//   at_max      - pointer has reached DEPTH (lane complete)
//   last        - this cycle's write completes the lane
//   ovf         - sticky: a strobe arrived after the lane was complete
module lane_wr_ptr #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          vld,
    output logic [AW-1:0] waddr,
    output logic          we,
    output logic          at_max,
    output logic          last,
    output logic          ovf
);

    localparam logic [AW:0] PTR_MAX  = (AW+1)'(DEPTH);
    localparam logic [AW:0] PTR_LAST = (AW+1)'(DEPTH - 1);

    logic [AW:0] ptr;

    assign waddr  = ptr[AW-1:0];
    assign at_max = (ptr == PTR_MAX);
    // A strobe coinciding with clear is discarded, never written.
    assign we     = vld & ~clear & ~at_max;
    assign last   = we & (ptr == PTR_LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ptr <= '0;
            ovf <= 1'b0;
        end else begin
            if (we)
                ptr <= ptr + 1'b1;
            if (vld && at_max)
                ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/result_collector.sv
// Collects the skewed output lanes of the systolic array into row-aligned
// storage and exposes complete rows through a one-cycle-latency read port.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (clears memory too)
//   clear      - restart collection, memory contents kept
//   vld, d     - per-lane strobe and data, lane i at d[i*WIDTH +: WIDTH]
//   rd_en      - row read request, rd_addr selects the row
//   rd_data    - row data one cycle after rd_en, rd_valid marks it
//   busy       - collection in progress
//   done       - single-cycle pulse once every lane has delivered DEPTH words
//   full       - level, all rows complete
//   overflow   - sticky, a strobe was dropped because its lane was complete
module result_collector
    import array_pkg::*;
#(
    parameter int STRIDE = DEF_STRIDE,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = 4,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic [STRIDE-1:0]       vld,
    input  logic [STRIDE*WIDTH-1:0] d,
    input  logic                    rd_en,
    input  logic [AW-1:0]           rd_addr,
    output logic [STRIDE*WIDTH-1:0] rd_data,
    output logic                    rd_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    full,
    output logic                    overflow
);

    logic [WIDTH-1:0] mem [DEPTH][STRIDE];

    logic [AW-1:0]     waddr [STRIDE];
    logic [STRIDE-1:0] we;
    logic [STRIDE-1:0] at_max;
    logic [STRIDE-1:0] last;
    logic [STRIDE-1:0] ovf;

    col_state_t state, state_nxt;
    logic       done_q;
    logic       rd_in_range;

    for (genvar i = 0; i < STRIDE; i++) begin : g_lane
        lane_wr_ptr #(
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_ptr (
            .clk    (clk),
            .rst    (rst),
            .clear  (clear),
            .vld    (vld[i]),
            .waddr  (waddr[i]),
            .we     (we[i]),
            .at_max (at_max[i]),
            .last   (last[i]),
            .ovf    (ovf[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++)
                for (int i = 0; i < STRIDE; i++)
                    mem[r][i] <= '0;
        end else begin
            for (int i = 0; i < STRIDE; i++)
                if (we[i])
                    mem[waddr[i]][i] <= d[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (|we)     state_nxt = COLLECT;
                COLLECT: if (&at_max) state_nxt = FULL;
                FULL:    state_nxt = FULL;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // done fires in the cycle right after the write that completes the last
    // lane, i.e. while the state register still shows COLLECT.
    always_ff @(posedge clk) begin
        if (rst || clear)
            done_q <= 1'b0;
        else
            done_q <= (&(at_max | last)) & ~(&at_max);
    end

    assign rd_in_range = ({1'b0, rd_addr} < (AW+1)'(DEPTH));

    // Non-blocking memory update gives read-before-write on a shared row.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                for (int i = 0; i < STRIDE; i++)
                    rd_data[i*WIDTH +: WIDTH] <= rd_in_range ? mem[rd_addr][i] : '0;
        end
    end

    assign busy     = (state == COLLECT);
    assign full     = (state == FULL);
    assign done     = done_q;
    assign overflow = |ovf;

endmodule

// File: tb/tb_result_collector.sv
module tb_result_collector;

    localparam int STRIDE = 4;
    localparam int WIDTH  = 32;
    localparam int DEPTH  = 4;
    localparam int AW     = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    clear;
    logic [STRIDE-1:0]       vld;
    logic [STRIDE*WIDTH-1:0] d;
    logic                    rd_en;
    logic [AW-1:0]           rd_addr;
    logic [STRIDE*WIDTH-1:0] rd_data;
    logic                    rd_valid;
    logic                    busy;
    logic                    done;
    logic                    full;
    logic                    overflow;

    int n_checks = 0;
    int n_fail   = 0;

    result_collector #(
        .STRIDE (STRIDE),
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .vld      (vld),
        .d        (d),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .done     (done),
        .full     (full),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [AW-1:0] addr,
                           output logic [STRIDE*WIDTH-1:0] data,
                           output logic valid);
        rd_en   = 1'b1;
        rd_addr = addr;
        step();
        rd_en   = 1'b0;
        data    = rd_data;
        valid   = rd_valid;
    endtask

    function automatic logic [STRIDE*WIDTH-1:0] row_val(input logic [31:0] base, input int r);
        logic [STRIDE*WIDTH-1:0] v;
        for (int i = 0; i < STRIDE; i++)
            v[i*WIDTH +: WIDTH] = base + 32'(4*r + i);
        return v;
    endfunction

    // All lanes strobed together for DEPTH cycles with base+4r+i.
    task automatic fill_all(input logic [31:0] base, output int done_cnt);
        done_cnt = 0;
        for (int r = 0; r < DEPTH; r++) begin
            vld = '1;
            d   = row_val(base, r);
            step();
            if (done) done_cnt++;
        end
        vld = '0;
        for (int k = 0; k < 2; k++) begin
            step();
            if (done) done_cnt++;
        end
    endtask

    task automatic test_reset();
        logic [STRIDE*WIDTH-1:0] data;
        logic valid;
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if ({rd_data, rd_valid, busy, done, full, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rd_data=%h rd_valid=%b busy=%b done=%b full=%b ovf=%b, want all 0",
                     rd_data, rd_valid, busy, done, full, overflow);
        end
        rst = 1'b0;
        do_read(2'd2, data, valid);
        n_checks++;
        if (data !== '0 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_read_row2: got data=%h valid=%b, want 0 valid=1", data, valid);
        end
    endtask

    task automatic test_skewed_fill();
        logic [STRIDE*WIDTH-1:0] data;
        logic valid;
        for (int c = 0; c < 10; c++) begin
            vld = '0;
            d   = '0;
            for (int i = 0; i < STRIDE; i++)
                if (c >= i && c <= i + 3) begin
                    vld[i] = 1'b1;
                    d[i*WIDTH +: WIDTH] = 32'hA0 + 32'(4*(c - i) + i);
                end
            step();
            n_checks++;
            if (done !== (c + 1 == 7) || busy !== (c + 1 >= 1 && c + 1 <= 7) || full !== (c + 1 >= 8)) begin
                n_fail++;
                $display("FAIL skew_cycle%0d: got done=%b busy=%b full=%b, want done=%b busy=%b full=%b",
                         c + 1, done, busy, full, (c + 1 == 7), (c + 1 >= 1 && c + 1 <= 7), (c + 1 >= 8));
            end
        end
        vld = '0;
        do_read(2'd1, data, valid);
        n_checks++;
        if (data !== {32'hA7, 32'hA6, 32'hA5, 32'hA4} || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL skew_row1: got %h valid=%b, want A7A6A5A4 valid=1", data, valid);
        end
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL skew_no_overflow: got %b want 0", overflow);
        end
    endtask

    task automatic test_overflow();
        logic [STRIDE*WIDTH-1:0] data;
        logic valid;
        int dn = 0;
        vld = 4'b0010;
        d   = '0;
        d[1*WIDTH +: WIDTH] = 32'hDEAD;
        step();
        vld = '0;
        if (done) dn++;
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: got %b want 1", overflow);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            if (done) dn++;
        end
        n_checks++;
        if (overflow !== 1'b1 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got ovf=%b full=%b want 1 1", overflow, full);
        end
        n_checks++;
        if (dn != 0) begin
            n_fail++;
            $display("FAIL ovf_no_done: got %0d done pulses want 0", dn);
        end
        do_read(2'd0, data, valid);
        n_checks++;
        if (data[1*WIDTH +: WIDTH] !== 32'hA1) begin
            n_fail++;
            $display("FAIL ovf_row0_lane1: got %h want 000000a1", data[1*WIDTH +: WIDTH]);
        end
    endtask

    task automatic test_clear_mid();
        logic [STRIDE*WIDTH-1:0] data;
        logic valid;
        int dn;
        clear = 1'b1;
        step();
        clear = 1'b0;
        n_checks++;
        if (full !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_from_full: got full=%b busy=%b ovf=%b done=%b want 0 0 0 0",
                     full, busy, overflow, done);
        end
        for (int r = 0; r < 2; r++) begin
            vld = '1;
            d   = row_val(32'hC0, r);
            step();
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_partial_busy: got %b want 1", busy);
        end
        vld   = '1;
        d     = {STRIDE{32'hEEEE}};
        clear = 1'b1;
        step();
        clear = 1'b0;
        vld   = '0;
        n_checks++;
        if (busy !== 1'b0 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_mid_idle: got busy=%b full=%b want 0 0", busy, full);
        end
        do_read(2'd0, data, valid);
        n_checks++;
        if (data !== row_val(32'hC0, 0)) begin
            n_fail++;
            $display("FAIL clear_mid_row0: got %h want %h", data, row_val(32'hC0, 0));
        end
        do_read(2'd2, data, valid);
        n_checks++;
        if (data !== row_val(32'hA0, 2)) begin
            n_fail++;
            $display("FAIL clear_mid_row2_kept: got %h want %h", data, row_val(32'hA0, 2));
        end
        fill_all(32'hB0, dn);
        n_checks++;
        if (dn != 1 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL refill_done: got pulses=%0d full=%b want 1 1", dn, full);
        end
        do_read(2'd0, data, valid);
        n_checks++;
        if (data !== {32'hB3, 32'hB2, 32'hB1, 32'hB0}) begin
            n_fail++;
            $display("FAIL refill_row0: got %h want b3b2b1b0", data);
        end
        do_read(2'd3, data, valid);
        n_checks++;
        if (data !== {32'hBF, 32'hBE, 32'hBD, 32'hBC}) begin
            n_fail++;
            $display("FAIL refill_row3: got %h want bfbebdbc", data);
        end
    endtask

    task automatic test_read_during_write();
        logic [STRIDE*WIDTH-1:0] data;
        logic valid;
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int r = 0; r < 3; r++) begin
            vld = 4'b0001;
            d   = '0;
            d[WIDTH-1:0] = 32'h11 * 32'(r + 1);
            step();
        end
        vld     = 4'b0001;
        d       = '0;
        d[WIDTH-1:0] = 32'h55;
        rd_en   = 1'b1;
        rd_addr = 2'd3;
        step();
        rd_en = 1'b0;
        vld   = '0;
        n_checks++;
        if (rd_data[WIDTH-1:0] !== 32'hBC || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rbw_old: got %h valid=%b want 000000bc valid=1", rd_data[WIDTH-1:0], rd_valid);
        end
        do_read(2'd3, data, valid);
        n_checks++;
        if (data !== {32'hBF, 32'hBE, 32'hBD, 32'h55}) begin
            n_fail++;
            $display("FAIL rbw_new: got %h want bfbebd55", data);
        end
        n_checks++;
        if (busy !== 1'b1 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL rbw_busy: got busy=%b full=%b want 1 0", busy, full);
        end
        do_read(2'd1, data, valid);
        n_checks++;
        if (data !== {32'hB7, 32'hB6, 32'hB5, 32'h22}) begin
            n_fail++;
            $display("FAIL rbw_row1: got %h want b7b6b522", data);
        end
    endtask

    task automatic test_reset_mid();
        logic [STRIDE*WIDTH-1:0] data;
        logic valid;
        int dn;
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int r = 0; r < 3; r++) begin
            vld = 4'b0001;
            d   = '0;
            d[WIDTH-1:0] = 32'h70 + 32'(r);
            step();
        end
        vld = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || full !== 1'b0 || overflow !== 1'b0 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got busy=%b full=%b ovf=%b rd_valid=%b want 0",
                     busy, full, overflow, rd_valid);
        end
        do_read(2'd0, data, valid);
        n_checks++;
        if (data !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_mem0: got %h want 0", data);
        end
        do_read(2'd3, data, valid);
        n_checks++;
        if (data !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_mem3: got %h want 0", data);
        end
        fill_all(32'h40, dn);
        n_checks++;
        if (dn != 1 || full !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_refill: got pulses=%0d full=%b ovf=%b want 1 1 0", dn, full, overflow);
        end
        do_read(2'd2, data, valid);
        n_checks++;
        if (data !== {32'h4B, 32'h4A, 32'h49, 32'h48}) begin
            n_fail++;
            $display("FAIL rst_refill_row2: got %h want 4b4a4948", data);
        end
    endtask

    initial begin
        rst     = 1'b0;
        clear   = 1'b0;
        vld     = '0;
        d       = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
        test_reset();
        test_skewed_fill();
        test_overflow();
        test_clear_mid();
        test_read_during_write();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
